// File: rtl/arilla_bus_arbiter.sv
// rtl/arilla_bus_arbiter.sv - N-master round-robin arbiter for the arilla bus
// Optional watchdog: define ARILLA_BUS_ARBITER_TIMEOUT_EN.
module arilla_bus_arbiter #(
  parameter int NumMasters = 2,
  parameter int DataWidth = 32,
  parameter int ByteAddressWidth = 32,
  parameter int TimeoutCycles = 256,
  localparam int WordAddressWidth = ByteAddressWidth - $clog2(DataWidth / 8),
  localparam int BeWidth = DataWidth / 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NumMasters*DataWidth-1:0]        m_data,
  input  logic [NumMasters*WordAddressWidth-1:0] m_address,
  input  logic [NumMasters*BeWidth-1:0]          m_byte_enable,
  input  logic [NumMasters-1:0]                  m_read,
  input  logic [NumMasters-1:0]                  m_write,
  output logic [NumMasters*DataWidth-1:0]        m_data_in,
  output logic [NumMasters-1:0]                  m_available,
  output logic [NumMasters-1:0]                  m_intercept,
  output logic [DataWidth-1:0]                   s_data,
  output logic [WordAddressWidth-1:0]            s_address,
  output logic [BeWidth-1:0]                     s_byte_enable,
  output logic                                   s_read,
  output logic                                   s_write,
  input  logic [DataWidth-1:0]                   s_data_in,
  input  logic                                   s_available,
  input  logic                                   s_intercept,
  output logic [NumMasters-1:0]                  grant,
  output logic                                   timeout
);

  localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [IdxW-1:0]     ptr;
  logic [IdxW-1:0]     gnt_idx;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     nxt_ptr;
  logic                win_valid;
  logic [NumMasters-1:0] req;
  logic                busy;
  logic                done;
  logic                abort;
  logic                fire;

  assign req  = m_read | m_write;
  assign busy = (state == BUSY);

  // Lowest requester at or above ptr wins; otherwise fall back to the lowest overall (wrap).
  always_comb begin
    win_valid = |req;
    win_idx   = '0;
    for (int i = NumMasters - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IdxW'(i);
    end
    for (int i = NumMasters - 1; i >= 0; i--) begin
      if (req[i] && (IdxW'(i) >= ptr)) win_idx = IdxW'(i);
    end
  end

  // grant is one-hot or zero, so an OR-mux yields idle-zero strobes for free.
  always_comb begin
    s_data        = '0;
    s_address     = '0;
    s_byte_enable = '0;
    for (int i = 0; i < NumMasters; i++) begin
      if (grant[i]) begin
        s_data        = s_data | m_data[i*DataWidth +: DataWidth];
        s_address     = s_address | m_address[i*WordAddressWidth +: WordAddressWidth];
        s_byte_enable = s_byte_enable | m_byte_enable[i*BeWidth +: BeWidth];
      end
    end
  end

  assign s_read  = |(m_read & grant);
  assign s_write = |(m_write & grant);

  assign done  = busy & s_available & (s_read | s_write);
  assign abort = busy & ~(s_read | s_write);

  assign m_available = grant & {NumMasters{done | fire}};
  assign m_intercept = grant & {NumMasters{s_intercept}};

  always_comb begin
    m_data_in = '0;
    for (int i = 0; i < NumMasters; i++) begin
      m_data_in[i*DataWidth +: DataWidth] = (fire && grant[i]) ? {DataWidth{1'b1}} : s_data_in;
    end
  end

  assign nxt_ptr = (gnt_idx == IdxW'(NumMasters - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      grant   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= BUSY;
            gnt_idx <= win_idx;
            grant   <= NumMasters'(1) << win_idx;
          end
        end
        BUSY: begin
          if (done || abort || fire) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles) + 1;

  logic [CntW-1:0] cnt;
  logic            timeout_q;

  assign fire    = busy && !done && (cnt == CntW'(TimeoutCycles - 1));
  assign timeout = timeout_q;

  // Holding the counter at zero while idle is what clears it on entry to BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!busy) cnt <= '0;
      else if (!done) cnt <= cnt + 1'b1;
      if (fire) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TimeoutCycles > 0);
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb/tb_arilla_bus_arbiter.sv - self-checking bench for arilla_bus_arbiter
// Vector table, corner-case sequences and randomized traffic against a reference model.
module tb_arilla_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int BW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] m_data;
  logic [N*AW-1:0] m_address;
  logic [N*BW-1:0] m_byte_enable;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N*DW-1:0] m_data_in;
  logic [N-1:0]    m_available;
  logic [N-1:0]    m_intercept;
  logic [DW-1:0]   s_data;
  logic [AW-1:0]   s_address;
  logic [BW-1:0]   s_byte_enable;
  logic            s_read;
  logic            s_write;
  logic [DW-1:0]   s_data_in;
  logic            s_available;
  logic            s_intercept;
  logic [N-1:0]    grant;
  logic            timeout;

  always #5 clk = ~clk;

  arilla_bus_arbiter #(
    .NumMasters(N), .DataWidth(DW), .ByteAddressWidth(32), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .m_data(m_data), .m_address(m_address),
    .m_byte_enable(m_byte_enable), .m_read(m_read), .m_write(m_write),
    .m_data_in(m_data_in), .m_available(m_available), .m_intercept(m_intercept),
    .s_data(s_data), .s_address(s_address), .s_byte_enable(s_byte_enable),
    .s_read(s_read), .s_write(s_write), .s_data_in(s_data_in),
    .s_available(s_available), .s_intercept(s_intercept), .grant(grant),
    .timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner = granted master or -1, ptr = next preferred master.
  int owner;
  int ptr;
  int bcnt;
  bit tflag;

  typedef struct {
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        sav;
    logic [31:0] sdin;
    logic [3:0]  eg;
    logic        ers;
    logic        ews;
    logic [3:0]  ema;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_fire();
    bit f;
    f = 1'b0;
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
    if (owner >= 0) begin
      f = !((m_read[owner] || m_write[owner]) && s_available) && (bcnt == TO - 1);
    end
`endif
    return f;
  endfunction

  task automatic check_model();
    logic [N-1:0]    ge, mae, mie;
    logic            rde, wre, dn, fr;
    logic [AW-1:0]   ae;
    logic [DW-1:0]   de;
    logic [BW-1:0]   be;
    logic [N*DW-1:0] mde;
    ge = '0; mae = '0; mie = '0; rde = 1'b0; wre = 1'b0; ae = '0; de = '0; be = '0;
    dn = 1'b0;
    if (owner >= 0) begin
      ge[owner] = 1'b1;
      rde = m_read[owner];
      wre = m_write[owner];
      ae  = m_address[owner*AW +: AW];
      de  = m_data[owner*DW +: DW];
      be  = m_byte_enable[owner*BW +: BW];
      dn  = s_available && (rde || wre);
      if (s_intercept) mie[owner] = 1'b1;
    end
    fr = model_fire();
    if (dn || fr) mae[owner] = 1'b1;
    for (int i = 0; i < N; i++) mde[i*DW +: DW] = s_data_in;
    if (fr) mde[owner*DW +: DW] = '1;
    chk("grant", grant, ge);
    chk("s_read", s_read, rde);
    chk("s_write", s_write, wre);
    chk("s_address", s_address, ae);
    chk("s_data", s_data, de);
    chk("s_byte_enable", s_byte_enable, be);
    chk("m_available", m_available, mae);
    chk("m_intercept", m_intercept, mie);
    chk("m_data_in", m_data_in, mde);
    chk("timeout", timeout, tflag);
  endtask

  task automatic model_update();
    bit rq, dn, fr, found;
    if (rst) begin
      owner = -1; ptr = 0; bcnt = 0; tflag = 1'b0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (!found && (m_read[c] || m_write[c])) begin
          owner = c;
          found = 1'b1;
        end
      end
      bcnt = 0;
    end else begin
      rq = m_read[owner] || m_write[owner];
      dn = rq && s_available;
      fr = model_fire();
      if (dn || fr || !rq) begin
        ptr = (owner + 1) % N;
        owner = -1;
        if (fr) tflag = 1'b1;
      end else begin
        bcnt++;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_addr();
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW] = AW'(32'h100 + i);
      m_data[i*DW +: DW] = 32'hA000_0000 + i;
      m_byte_enable[i*BW +: BW] = BW'(i + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; m_read = '0; m_write = '0; s_available = 1'b0; s_intercept = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_read = '0; m_write = '0; s_available = 1'b0; s_intercept = 1'b0;
    s_data_in = '0; m_data = '0; m_address = '0; m_byte_enable = '0;
    set_addr();
    repeat (2) @(posedge clk);
    owner = -1; ptr = 0; bcnt = 0; tflag = 1'b0;
    @(negedge clk);
    do_reset();

    //            rst   rd       wr       sav   sdin          eg       ers   ews   ema
    tbl[0]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,        4'b0001, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,        4'b0001, 1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 32'hDEADBEEF, 4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 4'b0011, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0011, 4'b0000, 1'b0, 32'h0,        4'b0010, 1'b1, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 1'b1, 32'hCAFEF00D, 4'b0010, 1'b1, 1'b0, 4'b0010};
    tbl[8]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,        4'b0001, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b0, 4'b0000};
    tbl[11] = '{1'b0, 4'b0000, 4'b1000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{1'b0, 4'b0000, 4'b1000, 1'b0, 32'h0,        4'b1000, 1'b0, 1'b1, 4'b0000};
    tbl[13] = '{1'b1, 4'b0000, 4'b1000, 1'b0, 32'h0,        4'b1000, 1'b0, 1'b1, 4'b0000};
    tbl[14] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[15] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 32'h12345678, 4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[16] = '{1'b0, 4'b1111, 4'b0010, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[17] = '{1'b0, 4'b1111, 4'b0010, 1'b0, 32'h0,        4'b0010, 1'b1, 1'b1, 4'b0000};

    for (int v = 0; v < 18; v++) begin
      rst = tbl[v].rst; m_read = tbl[v].rd; m_write = tbl[v].wr;
      s_available = tbl[v].sav; s_data_in = tbl[v].sdin;
      #1;
      chk($sformatf("tbl%0d_grant", v), grant, tbl[v].eg);
      chk($sformatf("tbl%0d_s_read", v), s_read, tbl[v].ers);
      chk($sformatf("tbl%0d_s_write", v), s_write, tbl[v].ews);
      chk($sformatf("tbl%0d_m_available", v), m_available, tbl[v].ema);
      chk($sformatf("tbl%0d_m_data_in", v), m_data_in, {N{tbl[v].sdin}});
      chk($sformatf("tbl%0d_timeout", v), timeout, 1'b0);
      cycle();
    end
    rst = 1'b0;

    // Master 1 waits behind a stalled master 0.
    do_reset();
    m_read = 4'b0001;
    cycle();
    m_read = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("stall_grant", grant, 4'b0001);
      chk("stall_m1_avail", m_available[1], 1'b0);
      cycle();
    end
    s_available = 1'b1; s_data_in = 32'h5555AAAA;
    #1 chk("stall_complete", m_available, 4'b0001);
    cycle();
    m_read = 4'b0010; s_available = 1'b0;
    #1 chk("stall_dead_cycle", grant, 4'b0000);
    cycle();
    #1 chk("stall_m1_granted", grant, 4'b0010);
    chk("stall_m1_addr", s_address, AW'(32'h101));
    cycle();
    m_read = '0;
    cycle();

    // All four write continuously; slave completes every BUSY cycle.
    do_reset();
    set_addr();
    m_write = 4'b1111; s_available = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] eg;
      eg = (k % 2 == 0) ? 4'b0000 : 4'b0001 << ((k / 2) % 4);
      #1;
      chk($sformatf("rr%0d_grant", k), grant, eg);
      if (k % 2 == 1) chk($sformatf("rr%0d_addr", k), s_address, AW'(32'h100 + (k / 2) % 4));
      cycle();
    end
    m_write = '0; s_available = 1'b0;
    cycle();

    // Slave never answers.
    do_reset();
    m_read = 4'b0001;
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
    for (int k = 0; k <= 10; k++) begin
      #1;
      if (k == 8) begin
        chk("to_forced_avail", m_available, 4'b0001);
        chk("to_all_ones", m_data_in[DW-1:0], 32'hFFFF_FFFF);
      end
      if (k == 9) begin
        chk("to_idle", grant, 4'b0000);
        chk("to_flag", timeout, 1'b1);
      end
      if (k == 10) begin
        chk("to_sticky", timeout, 1'b1);
        chk("to_regrant", grant, 4'b0001);
      end
      cycle();
    end
`else
    for (int k = 0; k < 20; k++) cycle();
    #1;
    chk("hold_grant", grant, 4'b0001);
    chk("hold_no_timeout", timeout, 1'b0);
    chk("hold_no_avail", m_available, 4'b0000);
`endif
    m_read = '0;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      m_read = 4'($urandom_range(0, 15));
      m_write = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      s_available = ($urandom_range(0, 3) == 0);
      s_intercept = ($urandom_range(0, 7) == 0);
      s_data_in = $urandom;
      for (int i = 0; i < N; i++) begin
        m_data[i*DW +: DW] = $urandom;
        m_address[i*AW +: AW] = AW'($urandom);
        m_byte_enable[i*BW +: BW] = BW'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arilla_bus_arbiter.md
Name: arilla_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the arilla bus (data, data_in, address, byte_enable, read, write, available, intercept).
- Successor to the point-to-point bus: generalised in master count, with round-robin arbitration, grant locking for the whole transfer, and abort handling.
- Sits between the core fetch/LSU ports plus the debug module and the system memory/peripheral fabric.

Parameters:
- NumMasters, 2, number of master channels; legal range 1..16 (1 = pass-through with registered grant).
- DataWidth, 32, data bus width in bits; multiple of 8.
- ByteAddressWidth, 32, byte address width; word address width = ByteAddressWidth - clog2(DataWidth/8).
- TimeoutCycles, 256, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_data  in  NumMasters*DataWidth  write data; master i occupies slice [i*DataWidth +: DataWidth]; same slicing for all m_* vectors.
- m_address  in  NumMasters*WordAddressWidth  word address per master.
- m_byte_enable  in  NumMasters*(DataWidth/8)  byte enables per master.
- m_read  in  NumMasters  read request per master.
- m_write  in  NumMasters  write request per master.
- m_data_in  out  NumMasters*DataWidth  read data; s_data_in broadcast to every slice.
- m_available  out  NumMasters  completion strobe; only the granted master's bit can be 1.
- m_intercept  out  NumMasters  s_intercept routed to the granted master only; 0 elsewhere.
- s_data  out  DataWidth  write data of the granted master.
- s_address  out  WordAddressWidth  address of the granted master.
- s_byte_enable  out  DataWidth/8  byte enables of the granted master.
- s_read  out  1  read strobe of the granted master.
- s_write  out  1  write strobe of the granted master.
- s_data_in  in  DataWidth  slave read data.
- s_available  in  1  slave completion.
- s_intercept  in  1  slave/debug intercept flag.
- grant  out  NumMasters  registered one-hot grant; 0 when idle.
- timeout  out  1  sticky watchdog flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset:
  - State IDLE; round-robin pointer = 0; grant = 0; timeout = 0.
  - All s_* strobes, m_available and m_intercept = 0.
  - Reset mid-transfer: strobes drop the cycle after rst is sampled; no completion is reported.
- Request: master i requests when m_read[i] | m_write[i].
- IDLE state:
  - Slave strobes are 0.
  - If any request is present, the winner is the first requester at index >= pointer, wrapping modulo NumMasters.
  - grant is registered to the winner and state moves to BUSY.
  - Latency: request at cycle 0 -> grant and s_read/s_write at cycle 1.
- BUSY state:
  - s_* driven combinationally from the granted slice.
  - s_available, s_data_in and s_intercept are routed to the granted master's m_available and m_intercept.
- Completion:
  - Condition: s_available & (s_read | s_write) in BUSY.
  - Next cycle: IDLE, grant = 0, pointer = (granted index + 1) mod NumMasters.
  - Requesters must drop their strobe in the cycle after seeing m_available.
- Abort: the granted master deasserts both read and write before completion -> IDLE next cycle; pointer advances as on completion; no m_available.
- Read and write asserted together: both forwarded unchanged; the arbiter does not resolve this.
- Non-granted masters: receive m_available = 0 and are held until granted; their inputs never reach the slave.
- Throughput: one dead IDLE cycle between consecutive grants, so back-to-back transfers take at least 2 cycles each.
- Fairness: with all masters requesting continuously, grants rotate 0, 1, ..., N-1, 0.

Optional Feature:
- Macro: ARILLA_BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering BUSY and increments each BUSY cycle without completion.
  - When the count reaches TimeoutCycles - 1 without completion, the arbiter forces completion in that cycle: m_available = 1 and m_data_in = all ones for the granted master; s_read/s_write still follow the master.
  - timeout sets and stays 1 until rst.
  - Next cycle is IDLE and the pointer advances.
- Disabled: no counter; timeout tied 0; BUSY may last indefinitely.

Test Plan:
- Single master 0 read, slave returns available in cycle 3 with s_data_in = 0xDEADBEEF -> grant = 01 in cycles 1-3, m_available[0] = 1 in cycle 3 with 0xDEADBEEF, grant = 00 in cycle 4.
- NumMasters = 4, all four write continuously, slave available every BUSY cycle -> grant order 0, 1, 2, 3, 0 with one IDLE cycle between grants; s_address always matches the granted master.
- Master 1 requests while master 0 is in BUSY with s_available held 0 for 5 cycles -> master 1 sees m_available[1] = 0 throughout; it is granted 2 cycles after master 0 completes (completion cycle, then one IDLE cycle).
- Master 0 drops its read in cycle 2 before any available -> IDLE in cycle 3, no m_available pulse, next grant goes to master 1 if it is requesting.
- rst asserted during BUSY -> cycle after: s_read = s_write = 0, grant = 0, timeout = 0, pointer = 0 (next all-request grant goes to master 0).
- TIMEOUT_EN with TimeoutCycles = 8, slave never available -> m_available = 1 with m_data_in = 0xFFFFFFFF in the 8th BUSY cycle; timeout = 1 and stays sticky.
